// File: rtl/store_rmw_unit.sv
// Store read-modify-write sequencer: merges byte/half stores into word-only memory.
// Optional RMW_WSTRB_EN: direct strobed writes (mem_wstrb port), no read phase.
module store_rmw_unit #(
   parameter int MEM_RD_LAT = 1
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [1:0]  req_size,
   output logic        done,
   output logic        err,
   output logic        busy,
   output logic [31:0] mem_addr,
   output logic        mem_re,
   input  logic [31:0] mem_rdata,
   output logic        mem_we,
`ifdef RMW_WSTRB_EN
   output logic [3:0]  mem_wstrb,
`endif
   output logic [31:0] mem_wdata
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_READ  = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_WRITE = 3'd3;
   localparam logic [2:0] S_ERR   = 3'd4;

   logic [2:0]  state_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [1:0]  size_q;
`ifndef RMW_WSTRB_EN
   logic [2:0]  cnt_q;
   logic [31:0] orig_q;
`endif

   logic        accept;
   logic        bad_req;
   logic [4:0]  shift;
   logic [31:0] lanemask;
   logic [31:0] ins;
   logic [31:0] merged;
   logic [3:0]  strb;

   assign accept = req_valid & req_ready;

   always_comb begin
      bad_req = (req_size == 2'b11)
              | ((req_size == 2'b01) & req_addr[0])
              | ((req_size == 2'b10) & (|req_addr[1:0]));
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         size_q  <= '0;
`ifndef RMW_WSTRB_EN
         cnt_q   <= '0;
         orig_q  <= '0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
                  size_q  <= req_size;
                  if (bad_req)
                     state_q <= S_ERR;
`ifdef RMW_WSTRB_EN
                  else
                     state_q <= S_WRITE;
`else
                  else if (req_size == 2'b10)
                     state_q <= S_WRITE;
                  else
                     state_q <= S_READ;
`endif
               end
            end
`ifndef RMW_WSTRB_EN
            S_READ: begin
               cnt_q   <= 3'(MEM_RD_LAT);
               state_q <= S_WAIT;
            end
            // read data is valid in the last counted cycle
            S_WAIT: begin
               cnt_q <= cnt_q - 3'd1;
               if (cnt_q == 3'd1) begin
                  orig_q  <= mem_rdata;
                  state_q <= S_WRITE;
               end
            end
`endif
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // little-endian lane placement of the right-justified store data
   always_comb begin
      case (size_q)
         2'b00: begin
            lanemask = 32'h0000_00FF;
            shift    = {addr_q[1:0], 3'b000};
            strb     = 4'b0001 << addr_q[1:0];
         end
         2'b01: begin
            lanemask = 32'h0000_FFFF;
            shift    = {addr_q[1], 4'b0000};
            strb     = 4'b0011 << {addr_q[1], 1'b0};
         end
         default: begin
            lanemask = '1;
            shift    = '0;
            strb     = 4'b1111;
         end
      endcase
      ins = (wdata_q & lanemask) << shift;
`ifdef RMW_WSTRB_EN
      merged = ins;
`else
      merged = (orig_q & ~(lanemask << shift)) | ins;
`endif
   end

   assign req_ready = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign mem_re    = (state_q == S_READ);
   assign mem_we    = (state_q == S_WRITE);
   assign done      = (state_q == S_WRITE);
   assign err       = (state_q == S_ERR);
   assign mem_addr  = busy ? {addr_q[31:2], 2'b00} : '0;
   assign mem_wdata = mem_we ? merged : '0;
`ifdef RMW_WSTRB_EN
   assign mem_wstrb = mem_we ? strb : '0;
`endif

endmodule

// File: tb/tb_store_rmw_unit.sv
// Scoreboard bench for store_rmw_unit with a latency-accurate word memory model.
// Honours RMW_WSTRB_EN the same way as the design.
module tb_store_rmw_unit;

   localparam int LAT = 3;

   logic        clk;
   logic        nrst;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [1:0]  req_size;
   logic        done;
   logic        err;
   logic        busy;
   logic [31:0] mem_addr;
   logic        mem_re;
   logic [31:0] mem_rdata;
   logic        mem_we;
   logic [31:0] mem_wdata;
`ifdef RMW_WSTRB_EN
   logic [3:0]  mem_wstrb;
`endif

   store_rmw_unit #(.MEM_RD_LAT(LAT)) dut (
      .clk       (clk),
      .nrst      (nrst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_size  (req_size),
      .done      (done),
      .err       (err),
      .busy      (busy),
      .mem_addr  (mem_addr),
      .mem_re    (mem_re),
      .mem_rdata (mem_rdata),
      .mem_we    (mem_we),
`ifdef RMW_WSTRB_EN
      .mem_wstrb (mem_wstrb),
`endif
      .mem_wdata (mem_wdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        is_err;
      logic        rmw;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
   } exp_t;

   exp_t        sbq[$];
   logic [31:0] mem     [logic [29:0]];
   logic [31:0] ref_mem [logic [29:0]];
   logic [31:0] pipe [LAT];
   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned we_cnt = 0;

   function automatic logic [31:0] mem_rd(input logic [29:0] i);
      return mem.exists(i) ? mem[i] : 32'h0;
   endfunction

   function automatic logic [31:0] ref_rd(input logic [29:0] i);
      return ref_mem.exists(i) ? ref_mem[i] : 32'h0;
   endfunction

   // memory responder: data only valid exactly LAT cycles after mem_re
   always @(posedge clk) begin
      logic [31:0] w;
      pipe[0] <= mem_re ? mem_rd(mem_addr[31:2]) : 32'hBAD0_BAD0;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
      if (mem_we) begin
         we_cnt++;
`ifdef RMW_WSTRB_EN
         w = mem_rd(mem_addr[31:2]);
         for (int b = 0; b < 4; b++)
            if (mem_wstrb[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
         mem[mem_addr[31:2]] = w;
`else
         mem[mem_addr[31:2]] = mem_wdata;
`endif
      end
   end
   assign mem_rdata = pipe[LAT-1];

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
      exp_t        e;
      logic [3:0]  sel;
      logic [7:0]  nb [4];
      logic [31:0] orig, full, part;
      int unsigned n, reads, rcyc, wes, done_n;
      logic        got;

      e.is_err = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
      e.addr   = {a[31:2], 2'b00};
      sel = 4'b0000;
      for (int unsigned i = 0; i < 4; i++) nb[i] = d[7:0];
      case (sz)
         2'b00: sel = 4'b0001 << a[1:0];
         2'b01: begin
            sel   = a[1] ? 4'b1100 : 4'b0011;
            nb[1] = d[15:8];
            nb[3] = d[15:8];
         end
         2'b10: begin
            sel = 4'b1111;
            for (int unsigned i = 0; i < 4; i++) nb[i] = d[8*i +: 8];
         end
         default: sel = 4'b0000;
      endcase
      orig = ref_rd(a[31:2]);
      for (int unsigned i = 0; i < 4; i++) begin
         full[8*i +: 8] = sel[i] ? nb[i] : orig[8*i +: 8];
         part[8*i +: 8] = sel[i] ? nb[i] : 8'h00;
      end
      e.strb = sel;
`ifdef RMW_WSTRB_EN
      e.rmw  = 1'b0;
      e.data = part;
`else
      e.rmw  = !e.is_err && sz != 2'b10;
      e.data = full;
`endif
      if (!e.is_err) ref_mem[a[31:2]] = full;
      sbq.push_back(e);

      @(negedge clk);
      req_valid = 1'b1;
      req_addr  = a;
      req_wdata = d;
      req_size  = sz;
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) check("accept_timeout", 32'(req_ready), 32'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_addr  = $urandom;
      req_wdata = $urandom;
      req_size  = 2'($urandom);

      reads = 0; rcyc = 0; wes = 0; done_n = 0; got = 1'b0;
      for (int unsigned c = 1; c <= 20 && !got; c++) begin
         @(negedge clk);
         if (mem_re) begin
            reads++;
            rcyc = c;
         end
         if (mem_we) wes++;
         if (done || err) begin
            got    = 1'b1;
            done_n = c;
         end
      end
      e = sbq.pop_front();
      if (!got) begin
         check("done_timeout", 32'(got), 32'd1);
      end else begin
         check("err", 32'(err), 32'(e.is_err));
         check("done", 32'(done), 32'(!e.is_err));
         check("latency", done_n, (e.is_err || !e.rmw) ? 32'd1 : 32'(2 + LAT));
         check("read_count", reads, 32'(e.rmw));
         check("write_count", wes, 32'(!e.is_err));
         if (e.rmw) check("read_cycle", rcyc, 32'd1);
         if (!e.is_err) begin
            check("mem_addr", mem_addr, e.addr);
            check("mem_wdata", mem_wdata, e.data);
`ifdef RMW_WSTRB_EN
            check("mem_wstrb", 32'(mem_wstrb), 32'(e.strb));
`endif
         end
      end
      @(negedge clk);
      check("ready_after", 32'(req_ready), 32'd1);
      check("busy_after", 32'(busy), 32'd0);
   endtask

   initial begin
      int unsigned we_before;
      nrst      = 1'b0;
      req_valid = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      req_size  = '0;
      mem[30'h40]     = 32'hC0DE_BABE;
      ref_mem[30'h40] = 32'hC0DE_BABE;
      mem[30'h81]     = 32'hDEAD_BEEF;
      ref_mem[30'h81] = 32'hDEAD_BEEF;

      repeat (3) @(posedge clk);
      #1;
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      @(negedge clk);
      nrst = 1'b1;
      @(negedge clk);
      check("rst_ready", 32'(req_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done | err | mem_re), 32'd0);

      do_store(32'h0000_0102, 32'h0000_00AB, 2'b00);
      do_store(32'h0000_0206, 32'h0000_1234, 2'b01);
      do_store(32'h0000_0300, 32'h1122_3344, 2'b10);
      do_store(32'h0000_0101, 32'h0000_BEEF, 2'b01);
      do_store(32'h0000_0302, 32'hCAFE_F00D, 2'b10);
      do_store(32'h0000_0300, 32'h0000_0001, 2'b11);
      // same-word back-to-back sub-word stores
      do_store(32'h0000_0100, 32'hFFFF_FF11, 2'b00);
      do_store(32'h0000_0103, 32'hFFFF_FF5A, 2'b00);
      do_store(32'h0000_0101, 32'h0000_0022, 2'b00);
      do_store(32'h0000_0204, 32'hABCD_9876, 2'b01);
      do_store(32'h0000_0206, 32'h0000_0000, 2'b01);
      do_store(32'h0000_0204, 32'h0BAD_CAFE, 2'b10);

      // async reset mid-store drops the write
      we_before = we_cnt;
      @(negedge clk);
      req_valid = 1'b1;
      req_addr  = 32'h0000_0400;
      req_wdata = 32'h0000_0077;
      req_size  = 2'b00;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
`ifdef RMW_WSTRB_EN
      repeat (1) @(negedge clk);
`else
      repeat (2) @(negedge clk);
`endif
      check("mid_busy", 32'(busy), 32'd1);
      nrst = 1'b0;
      #1;
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_strobes", {28'd0, mem_re, mem_we, done, err}, 32'd0);
      check("arst_mem_addr", mem_addr, 32'd0);
      check("arst_mem_wdata", mem_wdata, 32'd0);
      repeat (LAT + 2) @(negedge clk);
      nrst = 1'b1;
      repeat (LAT + 2) @(negedge clk);
      check("arst_no_write", we_cnt, we_before);
      check("arst_ready", 32'(req_ready), 32'd1);
      do_store(32'h0000_0003, 32'h0000_0055, 2'b00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/store_rmw_unit.md
Name: store_rmw_unit

Overview:
- Sequences sub-word stores (byte, halfword) into the word-only data memory as read-modify-write; full-word stores are written directly.
- Sits between the datapath store path and the data memory port.
- Performs the same lane merge as the byte-modify logic, extended to halfwords and registered across a multi-cycle memory handshake.

Parameters:
- MEM_RD_LAT, 1, cycles from mem_re to valid mem_rdata; legal range 1..4.

Ports:
- clk  input  1  clock, rising edge
- nrst  input  1  asynchronous active-low reset
- req_valid  input  1  store request present
- req_ready  output  1  unit can accept; high only in IDLE
- req_addr  input  32  byte address of store
- req_wdata  input  32  store data, right-justified (byte in [7:0], half in [15:0])
- req_size  input  2  00 byte, 01 half, 10 word, 11 reserved
- done  output  1  one-cycle pulse: store committed
- err  output  1  one-cycle pulse: misaligned or reserved size, no memory access
- busy  output  1  high in any state except IDLE
- mem_addr  output  32  word address: {req_addr[31:2], 2'b00}
- mem_re  output  1  memory read strobe
- mem_rdata  input  32  read data, valid MEM_RD_LAT cycles after mem_re
- mem_we  output  1  memory write strobe
- mem_wdata  output  32  merged word

Behaviour:
- Reset (async, nrst=0): FSM→IDLE; done, err, mem_re, mem_we=0; mem_addr, mem_wdata=0; req_ready=1 after release. In-flight store is dropped; no write is issued.
- Accept: req_valid & req_ready at a rising edge. addr, wdata and size are latched; later input changes are ignored.
- Alignment check at accept:
  - half with addr[0]=1 → err
  - word with addr[1:0]≠0 → err
  - size 11 → err
  - err pulses in the ERR state one cycle later; FSM returns to IDLE next; no mem_re or mem_we.
- States:
  - IDLE: req_ready=1. On accept: word→WRITE; byte/half→READ; bad request→ERR.
  - READ: mem_re=1 for exactly one cycle; load counter with MEM_RD_LAT; →WAIT.
  - WAIT: decrement counter each cycle. At the edge ending the cycle where counter==1, capture mem_rdata into orig_q; →WRITE.
  - WRITE: mem_we=1 and done=1 for exactly one cycle; mem_wdata=merged; →IDLE.
  - ERR: err=1 for one cycle; →IDLE.
- mem_addr holds the latched word address from the cycle after accept through WRITE; 0 in IDLE.
- Merge (little-endian lanes):
  - byte: shift=addr[1:0]*8, mask=0xFF<<shift
  - half: shift=addr[1]*16, mask=0xFFFF<<shift
  - merged = (orig_q & ~mask) | ((wdata & lanemask) << shift)
  - word: merged=wdata; no read is performed.
- Latency, accept at cycle 0:
  - word: mem_we/done in cycle 1
  - byte/half: mem_re in cycle 1, mem_we/done in cycle 2+MEM_RD_LAT
  - next accept possible one cycle after done/err
- Back-to-back stores to the same word: the second RMW reads after the first write, so no hazard. No request queueing.
- req_valid while busy is ignored; the requester must hold req_valid until req_ready.

Optional Feature:
- RMW_WSTRB_EN defined:
  - adds output mem_wstrb[3:0]; all sizes go IDLE→WRITE; mem_re is never asserted.
  - mem_wdata = (wdata&lanemask)<<shift.
  - mem_wstrb: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<(addr[1]*2); word = 4'b1111.
  - mem_wstrb=0 outside WRITE.
  - Byte/half latency equals word latency (1 cycle).
- Undefined: no mem_wstrb port; RMW sequence as above.

Test Plan:
- sb: addr=0x102, wdata=0xAB, mem word=0xC0DEBABE, LAT=1 → mem_re cycle 1, mem_addr=0x100; mem_we+done cycle 3, mem_wdata=0xC0ABBABE.
- sh: addr=0x206, wdata=0x1234, mem word=0xDEADBEEF, LAT=3 → mem_we cycle 5, mem_wdata=0x1234BEEF.
- sw: addr=0x300, wdata=0x11223344 → no mem_re; mem_we+done cycle 1, mem_wdata=0x11223344.
- Misaligned and reserved:
  - sh at 0x101 → err pulse cycle 1; mem_re=mem_we=0 throughout; req_ready=1 cycle 2.
  - sw at 0x302 → same as above.
  - size=11 → same as above.
- nrst low during WAIT of an sb → outputs 0 immediately, no mem_we ever; after release, a new sb at 0x003 with wdata 0x55 over word 0x00000000 → mem_wdata=0x55000000.
- RMW_WSTRB_EN, sb at 0x001 with wdata 0x7F → cycle 1: mem_we=1, mem_wstrb=0010, mem_wdata=0x00007F00, mem_re never asserted.
